setcc_pred_unit: RTL and testbench
==================================

# setcc_pred_unit

Pipelined, parametrised condition-evaluation unit that owns the core's architectural flags register and a file of NUM_PRED predicate bits. Each request compares the masked flags against a masked expected pattern, combines the match with a source predicate under a 3-bit op, and writes the result to a destination predicate. The unit sits between the decode/issue stage, which sends requests, and the flag-producing ALU, which writes flags. Results are returned over a valid/ready stream.

## Interface
- FLAG_W, 4, width of flags, mask and expected pattern
- NUM_PRED, 8, number of predicate registers (≥2); IDX_W = $clog2(NUM_PRED) derived
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flags_we  in  1  load flags_in into flags register this edge
- flags_in  in  FLAG_W  new flags value
- req_valid  in  1  request present
- req_ready  out  1  unit accepts request this cycle
- req_op  in  3  combine op
- req_mask  in  FLAG_W  compare mask
- req_expected  in  FLAG_W  expected flag pattern
- req_src  in  IDX_W  source predicate index
- req_dst  in  IDX_W  destination predicate index
- res_valid  out  1  result present
- res_ready  in  1  consumer takes result
- res_s  out  1  computed predicate value
- res_dst  out  IDX_W  destination index of result
- flags_q  out  FLAG_W  current flags register
- pred_q  out  NUM_PRED  all predicate bits; bit 0 reads 1

## Operation
- match = ((flags_q & mask) == (expected & mask)); mask = 0 gives match = 1.
- prev = pred[src]; pred[0] is constant 1, and writes to index 0 are discarded.
- Ops: 000 SET s=match; 001 AND s=prev&match; 010 OR s=prev|match; 011 XOR s=prev^match; 100 SETN s=~match; 101 ANDN s=prev&~match; 110 ORN s=prev|~match; 111 MOV s=prev (flags ignored).
- Stage S1: the request register, loaded on req_valid && req_ready. Evaluation is combinational from the S1 contents, flags_q and pred_q.
- Stage S2: the result register (res_s, res_dst, res_valid).
- advance = S1 valid && (!S2 valid || res_ready). On advance, S2 is loaded and pred[dst] is written on the same edge.
- req_ready = !S1 valid || advance. Sustained throughput is one request per cycle.
- S2 clears when res_ready is high and no advance occurs.

## Timing
- Reset (asynchronous): flags_q=0, pred_q=1 (bit 0 only), S1 and S2 invalid, res_s=0, res_dst=0, req_ready=1.
- Latency: a request accepted at edge N gives res_valid=1 after edge N+1. The predicate write is visible on pred_q after the same edge N+1.
- Dependent back-to-back requests (B.src = A.dst) need no stall. B evaluates in the cycle after A's write.
- If flags_we is high in the cycle S1 evaluates, evaluation uses the old flags_q. The new flags apply from the next cycle.
- If res_ready is low with S2 full, S1 holds. When S1 is also full, req_ready=0. S1 contents and evaluation inputs other than pred and flags stay stable.
- A held S1 re-evaluates each cycle with current flags and preds. The value written is the one computed at the advance edge.
- Reset mid-operation discards in-flight requests. No predicate write occurs for them.

## Structure
- Package setcc_pkg holds:
  - the op enum (SETCC_SET … SETCC_MOV, 3 bits);
  - a request struct {op, mask, expected, src, dst} parametrised through FLAG_W and IDX_W localparams;
  - the function evaluating match and the op.
- One sub-module, setcc_eval: purely combinational (flags, mask, expected, prev, op → s), parametrised by FLAG_W.
- The top level holds the S1/S2 registers, the predicate file and the flags register.

## Test plan
- Reset, then flags_we with 4'b1010. Request SET mask=1111 expected=1010 dst=3. Required: res_s=1 one cycle after acceptance, pred_q[3]=1.
- Request AND src=3 dst=3 mask=0010 expected=0000, issued back-to-back after the previous request. Required: res_s=0, pred_q[3]=0, req_ready stays 1 throughout.
- Hold res_ready=0 and issue 3 requests. Required: two are accepted, then req_ready=0. Release res_ready: results drain in order, one per cycle, with correct res_dst.
- Request SET dst=0 with a match. Required: res_s=1, res_dst=0, pred_q[0] stays 1. Then MOV src=0 dst=5 gives pred_q[5]=1.
- Same cycle as S1 evaluation, flags_we=1 with flags_in=0000 while flags_q=1111. SETN mask=1111 expected=1111 uses the old flags. Required: res_s=0; a repeat request gives res_s=1.
- Assert rst_n low while S1 and S2 are full. Required: res_valid=0 immediately, pred_q=1, flags_q=0, and no late writes after release.

Source files
------------

// File: rtl/setcc_pkg.sv
// rtl/setcc_pkg.sv - shared types, sizes and the op combine function for setcc_pred_unit
package setcc_pkg;

  localparam int SETCC_FLAG_W   = 4;
  localparam int SETCC_NUM_PRED = 8;
  localparam int SETCC_IDX_W    = $clog2(SETCC_NUM_PRED);

  typedef enum logic [2:0] {
    SETCC_SET  = 3'b000,
    SETCC_AND  = 3'b001,
    SETCC_OR   = 3'b010,
    SETCC_XOR  = 3'b011,
    SETCC_SETN = 3'b100,
    SETCC_ANDN = 3'b101,
    SETCC_ORN  = 3'b110,
    SETCC_MOV  = 3'b111
  } setcc_op_e;

  typedef struct packed {
    setcc_op_e                op;
    logic [SETCC_FLAG_W-1:0]  mask;
    logic [SETCC_FLAG_W-1:0]  expected;
    logic [SETCC_IDX_W-1:0]   src;
    logic [SETCC_IDX_W-1:0]   dst;
  } setcc_req_t;

  function automatic logic setcc_match(input logic [SETCC_FLAG_W-1:0] flags,
                                       input logic [SETCC_FLAG_W-1:0] mask,
                                       input logic [SETCC_FLAG_W-1:0] expected);
    return ((flags & mask) == (expected & mask));
  endfunction

  function automatic logic setcc_combine(input setcc_op_e op,
                                         input logic      prev,
                                         input logic      match);
    logic s;
    case (op)
      SETCC_SET:  s = match;
      SETCC_AND:  s = prev & match;
      SETCC_OR:   s = prev | match;
      SETCC_XOR:  s = prev ^ match;
      SETCC_SETN: s = ~match;
      SETCC_ANDN: s = prev & ~match;
      SETCC_ORN:  s = prev | ~match;
      SETCC_MOV:  s = prev;
      default:    s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/setcc_eval.sv
// rtl/setcc_eval.sv - combinational flag match and predicate combine
module setcc_eval
  import setcc_pkg::*;
#(
  parameter int FLAG_W = SETCC_FLAG_W
) (
  input  logic [FLAG_W-1:0] flags_i,
  input  logic [FLAG_W-1:0] mask_i,
  input  logic [FLAG_W-1:0] expected_i,
  input  logic              prev_i,
  input  setcc_op_e         op_i,
  output logic              s_o
);

  logic match;

  // An all-zero mask compares nothing and therefore always matches.
  assign match = ((flags_i & mask_i) == (expected_i & mask_i));
  assign s_o   = setcc_combine(op_i, prev_i, match);

endmodule

// File: rtl/setcc_pred_unit.sv
// rtl/setcc_pred_unit.sv - two-stage condition evaluator owning the flags and predicate registers
module setcc_pred_unit
  import setcc_pkg::*;
#(
  parameter int FLAG_W   = SETCC_FLAG_W,
  parameter int NUM_PRED = SETCC_NUM_PRED,
  parameter int IDX_W    = $clog2(NUM_PRED)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flags_we,
  input  logic [FLAG_W-1:0]   flags_in,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [FLAG_W-1:0]   req_mask,
  input  logic [FLAG_W-1:0]   req_expected,
  input  logic [IDX_W-1:0]    req_src,
  input  logic [IDX_W-1:0]    req_dst,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                res_s,
  output logic [IDX_W-1:0]    res_dst,
  output logic [FLAG_W-1:0]   flags_q,
  output logic [NUM_PRED-1:0] pred_q
);

  logic                s1_valid_q;
  setcc_op_e           s1_op_q;
  logic [FLAG_W-1:0]   s1_mask_q;
  logic [FLAG_W-1:0]   s1_exp_q;
  logic [IDX_W-1:0]    s1_src_q;
  logic [IDX_W-1:0]    s1_dst_q;

  logic                s2_valid_q;
  logic                res_s_q;
  logic [IDX_W-1:0]    res_dst_q;

  // Predicate 0 is hard-wired to 1, so only entries 1..NUM_PRED-1 are stored.
  logic [NUM_PRED-1:1] pred_hi_q;

  logic advance;
  logic accept;
  logic prev;
  logic eval_s;

  assign pred_q    = {pred_hi_q, 1'b1};
  assign advance   = s1_valid_q && (!s2_valid_q || res_ready);
  assign req_ready = !s1_valid_q || advance;
  assign accept    = req_valid && req_ready;
  assign prev      = pred_q[s1_src_q];

  assign res_valid = s2_valid_q;
  assign res_s     = res_s_q;
  assign res_dst   = res_dst_q;

  setcc_eval #(.FLAG_W(FLAG_W)) u_eval (
    .flags_i    (flags_q),
    .mask_i     (s1_mask_q),
    .expected_i (s1_exp_q),
    .prev_i     (prev),
    .op_i       (s1_op_q),
    .s_o        (eval_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (flags_we) begin
      flags_q <= flags_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= SETCC_SET;
      s1_mask_q  <= '0;
      s1_exp_q   <= '0;
      s1_src_q   <= '0;
      s1_dst_q   <= '0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_op_q    <= setcc_op_e'(req_op);
      s1_mask_q  <= req_mask;
      s1_exp_q   <= req_expected;
      s1_src_q   <= req_src;
      s1_dst_q   <= req_dst;
    end else if (advance) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      res_s_q    <= 1'b0;
      res_dst_q  <= '0;
    end else if (advance) begin
      s2_valid_q <= 1'b1;
      res_s_q    <= eval_s;
      res_dst_q  <= s1_dst_q;
    end else if (res_ready) begin
      s2_valid_q <= 1'b0;
    end
  end

  // The predicate write shares the advance edge with the S2 load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_hi_q <= '0;
    end else if (advance) begin
      for (int i = 1; i < NUM_PRED; i++) begin
        if (s1_dst_q == IDX_W'(i)) begin
          pred_hi_q[i] <= eval_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_setcc_pred_unit.sv
// tb/tb_setcc_pred_unit.sv - directed self-checking bench for setcc_pred_unit
module tb_setcc_pred_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flags_we;
  logic [3:0] flags_in;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [3:0] req_mask;
  logic [3:0] req_expected;
  logic [2:0] req_src;
  logic [2:0] req_dst;
  logic       res_valid;
  logic       res_ready;
  logic       res_s;
  logic [2:0] res_dst;
  logic [3:0] flags_q;
  logic [7:0] pred_q;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  setcc_pred_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flags_we     (flags_we),
    .flags_in     (flags_in),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_mask     (req_mask),
    .req_expected (req_expected),
    .req_src      (req_src),
    .req_dst      (req_dst),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_s        (res_s),
    .res_dst      (res_dst),
    .flags_q      (flags_q),
    .pred_q       (pred_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [3:0] mask, input logic [3:0] exp,
                           input logic [2:0] src, input logic [2:0] dst);
    req_valid    = 1'b1;
    req_op       = op;
    req_mask     = mask;
    req_expected = exp;
    req_src      = src;
    req_dst      = dst;
  endtask

  initial begin
    rst_n = 1'b0; flags_we = 1'b0; flags_in = '0; req_valid = 1'b0; req_op = '0;
    req_mask = '0; req_expected = '0; req_src = '0; req_dst = '0; res_ready = 1'b1;
    #12;
    chk("rst_flags", flags_q, 4'h0);
    chk("rst_pred", pred_q, 8'h01);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_res_s", res_s, 1'b0);
    chk("rst_res_dst", res_dst, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load flags, then SET followed back-to-back by a dependent AND.
    flags_we = 1'b1; flags_in = 4'b1010;
    step();
    flags_we = 1'b0;
    chk("flags_load", flags_q, 4'b1010);
    drive_req(3'b000, 4'b1111, 4'b1010, 3'd0, 3'd3);
    step();
    chk("a_ready", req_ready, 1'b1);
    drive_req(3'b001, 4'b0010, 4'b0000, 3'd3, 3'd3);
    step();
    chk("a_res_valid", res_valid, 1'b1);
    chk("a_res_s", res_s, 1'b1);
    chk("a_res_dst", res_dst, 3'd3);
    chk("a_pred3", pred_q[3], 1'b1);
    chk("b_ready", req_ready, 1'b1);
    req_valid = 1'b0;
    step();
    chk("b_res_valid", res_valid, 1'b1);
    chk("b_res_s", res_s, 1'b0);
    chk("b_pred3", pred_q[3], 1'b0);
    step();
    chk("b_drain", res_valid, 1'b0);

    // Backpressure: two accepted, third stalls, then in-order drain.
    res_ready = 1'b0;
    drive_req(3'b000, 4'b0000, 4'b0000, 3'd0, 3'd1);
    step();
    chk("bp_ready1", req_ready, 1'b1);
    drive_req(3'b100, 4'b0000, 4'b0000, 3'd0, 3'd2);
    step();
    chk("bp_ready2", req_ready, 1'b0);
    drive_req(3'b111, 4'b0000, 4'b0000, 3'd0, 3'd4);
    step();
    chk("bp_hold_ready", req_ready, 1'b0);
    chk("bp_hold_valid", res_valid, 1'b1);
    chk("bp_hold_dst", res_dst, 3'd1);
    chk("bp_hold_s", res_s, 1'b1);
    res_ready = 1'b1;
    #1;
    chk("bp_release_ready", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    chk("bp_r2_dst", res_dst, 3'd2);
    chk("bp_r2_s", res_s, 1'b0);
    chk("bp_r2_valid", res_valid, 1'b1);
    step();
    chk("bp_r3_dst", res_dst, 3'd4);
    chk("bp_r3_s", res_s, 1'b1);
    chk("bp_pred", pred_q, 8'h13);
    step();
    chk("bp_drain", res_valid, 1'b0);

    // Writes to predicate 0 are dropped; reading it yields 1.
    drive_req(3'b000, 4'b0000, 4'b0000, 3'd0, 3'd0);
    step();
    drive_req(3'b111, 4'b1111, 4'b0000, 3'd0, 3'd5);
    step();
    req_valid = 1'b0;
    chk("p0_res_s", res_s, 1'b1);
    chk("p0_res_dst", res_dst, 3'd0);
    chk("p0_pred", pred_q, 8'h13);
    step();
    chk("mov_res_s", res_s, 1'b1);
    chk("mov_pred", pred_q, 8'h33);
    step();

    // A flags write in the evaluation cycle is not seen until the next cycle.
    flags_we = 1'b1; flags_in = 4'b1111;
    step();
    flags_we = 1'b0;
    drive_req(3'b100, 4'b1111, 4'b1111, 3'd0, 3'd6);
    step();
    req_valid = 1'b0;
    flags_we = 1'b1; flags_in = 4'b0000;
    step();
    flags_we = 1'b0;
    chk("hz_res_s", res_s, 1'b0);
    chk("hz_flags", flags_q, 4'h0);
    chk("hz_pred6", pred_q[6], 1'b0);
    drive_req(3'b100, 4'b1111, 4'b1111, 3'd0, 3'd6);
    step();
    req_valid = 1'b0;
    step();
    chk("hz2_res_s", res_s, 1'b1);
    chk("hz2_pred", pred_q, 8'h73);

    // Asynchronous reset with both stages full.
    flags_we = 1'b1; flags_in = 4'b0101;
    res_ready = 1'b0;
    drive_req(3'b100, 4'b0000, 4'b0000, 3'd0, 3'd7);
    step();
    flags_we = 1'b0;
    drive_req(3'b000, 4'b0000, 4'b0000, 3'd0, 3'd2);
    step();
    req_valid = 1'b0;
    chk("pre_rst_ready", req_ready, 1'b0);
    chk("pre_rst_valid", res_valid, 1'b1);
    chk("pre_rst_flags", flags_q, 4'b0101);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", res_valid, 1'b0);
    chk("mid_rst_pred", pred_q, 8'h01);
    chk("mid_rst_flags", flags_q, 4'h0);
    chk("mid_rst_ready", req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    step();
    step();
    step();
    chk("post_rst_pred", pred_q, 8'h01);
    chk("post_rst_valid", res_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
